// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle and register-file write port.
// Also carries forwarding mirror and retire count.
interface wb_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          m_valid;
  logic          m_wen;
  logic [AW-1:0] m_waddr;
  logic [2:0]    m_wb_sel;
  logic [DW-1:0] m_alu;
  logic [DW-1:0] m_mem;
  logic [2:0]    m_ld_type;
  logic [DW-1:0] m_pc;
  logic          m_hilo_we;
  logic [DW-1:0] m_hi;
  logic [DW-1:0] m_lo;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          regfilesrc;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic [31:0]   retired;

  modport master (
    output m_valid, m_wen, m_waddr, m_wb_sel,
    output m_alu, m_mem, m_ld_type, m_pc,
    output m_hilo_we, m_hi, m_lo,
    input  waddr, wdata, regfilesrc,
    input  fwd_valid, fwd_addr, fwd_data,
    input  retired
  );

  modport slave (
    input  m_valid, m_wen, m_waddr, m_wb_sel,
    input  m_alu, m_mem, m_ld_type, m_pc,
    input  m_hilo_we, m_hi, m_lo,
    output waddr, wdata, regfilesrc,
    output fwd_valid, fwd_addr, fwd_data,
    output retired
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load
// extension, HI/LO and retired counter.
module wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  flush,
  wb_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [2:0]    wb_sel;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [2:0]    ld_type;
    logic [DW-1:0] pc;
    logic          hilo_we;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } wb_t;

  wb_t           wb_q, wb_d;
  logic [DW-1:0] hi_q, lo_q;
  logic [31:0]   ret_q;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] wdata;
  logic          we;

  // Next WB register: flush beats stall.
  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d = '0;
    end else if (!stall) begin
      wb_d.valid   = bus.m_valid;
      wb_d.wen     = bus.m_wen;
      wb_d.waddr   = bus.m_waddr;
      wb_d.wb_sel  = bus.m_wb_sel;
      wb_d.alu     = bus.m_alu;
      wb_d.mem     = bus.m_mem;
      wb_d.ld_type = bus.m_ld_type;
      wb_d.pc      = bus.m_pc;
      wb_d.hilo_we = bus.m_hilo_we;
      wb_d.hi      = bus.m_hi;
      wb_d.lo      = bus.m_lo;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  end

  // HI/LO commit from the instruction in WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_q.valid && wb_q.hilo_we) begin
      hi_q <= wb_q.hi;
      lo_q <= wb_q.lo;
    end
  end

  // Count every instruction leaving WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ret_q <= '0;
    else if (wb_q.valid && !stall)
      ret_q <= ret_q + 32'd1;
  end

  // Little-endian byte/half pick.
  always_comb begin
    byte_s = wb_q.mem[7:0];
    unique case (wb_q.alu[1:0])
      2'd1:    byte_s = wb_q.mem[15:8];
      2'd2:    byte_s = wb_q.mem[23:16];
      2'd3:    byte_s = wb_q.mem[31:24];
      default: byte_s = wb_q.mem[7:0];
    endcase
    half_s = wb_q.alu[1] ? wb_q.mem[31:16]
                         : wb_q.mem[15:0];
  end

  // Load extension; unknown types act as LW.
  always_comb begin
    ld_data = wb_q.mem;
    unique case (wb_q.ld_type)
      3'd1: ld_data = {{(DW-8){byte_s[7]}}, byte_s};
      3'd2: ld_data = {{(DW-8){1'b0}}, byte_s};
      3'd3: ld_data = {{(DW-16){half_s[15]}}, half_s};
      3'd4: ld_data = {{(DW-16){1'b0}}, half_s};
      default: ld_data = wb_q.mem;
    endcase
  end

  // Write-back source select; unknown acts as ALU.
  always_comb begin
    wdata = wb_q.alu;
    unique case (wb_q.wb_sel)
      3'd1:    wdata = ld_data;
      3'd2:    wdata = wb_q.pc + DW'(8);
      3'd3:    wdata = hi_q;
      3'd4:    wdata = lo_q;
      default: wdata = wb_q.alu;
    endcase
  end

  assign we = wb_q.valid & wb_q.wen
            & (wb_q.waddr != '0);

  assign bus.waddr      = wb_q.waddr;
  assign bus.wdata      = wdata;
  assign bus.regfilesrc = we;
  assign bus.fwd_valid  = we;
  assign bus.fwd_addr   = wb_q.waddr;
  assign bus.fwd_data   = wdata;
  assign bus.retired    = ret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage.
// Each task drives its scenario and checks inline.
module tb_wb_stage;

  logic clk;
  logic rst;
  logic stall;
  logic flush;
  int   total;
  int   bad;

  wb_stage_if #(.DW(32), .AW(5)) bus ();

  wb_stage #(.DW(32), .AW(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .stall(stall),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(
    input logic        v,
    input logic        wen,
    input logic [4:0]  wa,
    input logic [2:0]  sel,
    input logic [31:0] alu,
    input logic [31:0] mem,
    input logic [2:0]  lt,
    input logic [31:0] pc,
    input logic        hwe,
    input logic [31:0] hi,
    input logic [31:0] lo
  );
    bus.m_valid   = v;
    bus.m_wen     = wen;
    bus.m_waddr   = wa;
    bus.m_wb_sel  = sel;
    bus.m_alu     = alu;
    bus.m_mem     = mem;
    bus.m_ld_type = lt;
    bus.m_pc      = pc;
    bus.m_hilo_we = hwe;
    bus.m_hi      = hi;
    bus.m_lo      = lo;
  endtask

  task automatic bubble();
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    bubble();
    #2;
    total++;
    if (bus.regfilesrc !== 1'b0 || bus.waddr !== 5'd0
        || bus.wdata !== 32'd0 || bus.fwd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: src=%b wa=%0d wd=%h fv=%b req 0",
               bus.regfilesrc, bus.waddr, bus.wdata, bus.fwd_valid);
    end
    total++;
    if (bus.retired !== 32'd0) begin
      bad++;
      $display("FAIL reset_ret: got %h req 0", bus.retired);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_alu();
    set_m(1, 1, 8, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if (bus.waddr !== 5'd8 || bus.wdata !== 32'h1234_5678
        || bus.regfilesrc !== 1'b1) begin
      bad++;
      $display("FAIL alu: wa=%0d wd=%h src=%b req 8 12345678 1",
               bus.waddr, bus.wdata, bus.regfilesrc);
    end
    total++;
    if (bus.fwd_valid !== 1'b1 || bus.fwd_addr !== 5'd8
        || bus.fwd_data !== 32'h1234_5678) begin
      bad++;
      $display("FAIL fwd: fv=%b fa=%0d fd=%h req 1 8 12345678",
               bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
    end
    set_m(1, 1, 9, 3'd7, 32'hCAFE_0001, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if (bus.wdata !== 32'hCAFE_0001) begin
      bad++;
      $display("FAIL sel7_alu: got %h req cafe0001", bus.wdata);
    end
    bubble();
    step();
    total++;
    if (bus.regfilesrc !== 1'b0) begin
      bad++;
      $display("FAIL bubble_src: got %b req 0", bus.regfilesrc);
    end
  endtask

  task automatic test_loads();
    logic [31:0] alus [9];
    logic [2:0]  lts  [9];
    logic [31:0] exps [9];
    alus = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h102,
             32'h103, 32'h100, 32'h100, 32'h102};
    lts  = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3,
             3'd3, 3'd4, 3'd0, 3'd6};
    exps = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF,
             32'h0000_0080, 32'hFFFF_80FF, 32'hFFFF_80FF,
             32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 9; i++) begin
      set_m(1, 1, 3, 3'd1, alus[i], 32'h80FF_7F01,
            lts[i], 0, 0, 0, 0);
      step();
      total++;
      if (bus.wdata !== exps[i]) begin
        bad++;
        $display("FAIL load%0d: got %h req %h",
                 i, bus.wdata, exps[i]);
      end
    end
    bubble();
    step();
  endtask

  task automatic test_link();
    logic [31:0] r0;
    set_m(1, 1, 31, 3'd2, 0, 0, 0, 32'h0040_0010, 0, 0, 0);
    step();
    total++;
    if (bus.waddr !== 5'd31 || bus.wdata !== 32'h0040_0018
        || bus.regfilesrc !== 1'b1) begin
      bad++;
      $display("FAIL jal: wa=%0d wd=%h src=%b req 31 00400018 1",
               bus.waddr, bus.wdata, bus.regfilesrc);
    end
    set_m(1, 1, 31, 3'd2, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    step();
    total++;
    if (bus.wdata !== 32'h0000_0004) begin
      bad++;
      $display("FAIL link_wrap: got %h req 00000004", bus.wdata);
    end
    r0 = bus.retired;
    set_m(1, 1, 0, 0, 32'h77, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if (bus.regfilesrc !== 1'b0 || bus.fwd_valid !== 1'b0) begin
      bad++;
      $display("FAIL r0_write: src=%b fv=%b req 0 0",
               bus.regfilesrc, bus.fwd_valid);
    end
    bubble();
    step();
    total++;
    if (bus.retired !== r0 + 32'd2) begin
      bad++;
      $display("FAIL r0_retire: got %0d req %0d",
               bus.retired, r0 + 32'd2);
    end
  endtask

  task automatic test_hilo();
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA, 32'hB);
    step();
    set_m(1, 1, 5, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if (bus.waddr !== 5'd5 || bus.wdata !== 32'hA
        || bus.regfilesrc !== 1'b1) begin
      bad++;
      $display("FAIL mfhi: wa=%0d wd=%h src=%b req 5 a 1",
               bus.waddr, bus.wdata, bus.regfilesrc);
    end
    set_m(1, 1, 6, 3'd4, 0, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if (bus.wdata !== 32'hB) begin
      bad++;
      $display("FAIL mflo: got %h req b", bus.wdata);
    end
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 32'h22);
    step();
    flush = 1'b1;
    bubble();
    step();
    flush = 1'b0;
    set_m(1, 1, 7, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if (bus.wdata !== 32'h11) begin
      bad++;
      $display("FAIL hi_flush: got %h req 11", bus.wdata);
    end
    bubble();
    step();
  endtask

  task automatic test_stall();
    logic [31:0] rb;
    set_m(1, 1, 8, 0, 32'h55, 0, 0, 0, 0, 0, 0);
    step();
    rb = bus.retired;
    stall = 1'b1;
    set_m(1, 1, 9, 0, 32'h66, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.waddr !== 5'd8 || bus.wdata !== 32'h55
          || bus.regfilesrc !== 1'b1 || bus.retired !== rb) begin
        bad++;
        $display("FAIL stall%0d: wa=%0d wd=%h src=%b ret=%0d req 8 55 1 %0d",
                 i, bus.waddr, bus.wdata, bus.regfilesrc,
                 bus.retired, rb);
      end
    end
    stall = 1'b0;
    step();
    total++;
    if (bus.retired !== rb + 32'd1 || bus.waddr !== 5'd9
        || bus.wdata !== 32'h66) begin
      bad++;
      $display("FAIL unstall: ret=%0d wa=%0d wd=%h req %0d 9 66",
               bus.retired, bus.waddr, bus.wdata, rb + 32'd1);
    end
    stall = 1'b1;
    flush = 1'b1;
    step();
    stall = 1'b0;
    flush = 1'b0;
    total++;
    if (bus.regfilesrc !== 1'b0 || bus.retired !== rb + 32'd1) begin
      bad++;
      $display("FAIL flush_stall: src=%b ret=%0d req 0 %0d",
               bus.regfilesrc, bus.retired, rb + 32'd1);
    end
    set_m(1, 1, 10, 0, 32'h99, 0, 0, 0, 0, 0, 0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (bus.regfilesrc !== 1'b0 || bus.retired !== rb + 32'd2) begin
      bad++;
      $display("FAIL flush: src=%b ret=%0d req 0 %0d",
               bus.regfilesrc, bus.retired, rb + 32'd2);
    end
    bubble();
    step();
  endtask

  task automatic test_reset_mid();
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 32'h0);
    step();
    set_m(1, 1, 5, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if (bus.wdata !== 32'h1234 || bus.regfilesrc !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst: wd=%h src=%b req 1234 1",
               bus.wdata, bus.regfilesrc);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (bus.regfilesrc !== 1'b0 || bus.retired !== 32'd0
        || bus.wdata !== 32'd0) begin
      bad++;
      $display("FAIL mid_rst: src=%b ret=%0d wd=%h req 0 0 0",
               bus.regfilesrc, bus.retired, bus.wdata);
    end
    step();
    rst = 1'b1;
    set_m(1, 1, 5, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if (bus.wdata !== 32'd0 || bus.regfilesrc !== 1'b1
        || bus.waddr !== 5'd5) begin
      bad++;
      $display("FAIL post_rst: wd=%h src=%b wa=%0d req 0 1 5",
               bus.wdata, bus.regfilesrc, bus.waddr);
    end
    bubble();
    step();
  endtask

  task automatic test_wrap();
    set_m(1, 1, 2, 0, 32'h1, 0, 0, 0, 0, 0, 0);
    step();
    force dut.ret_q = 32'hFFFF_FFFF;
    #1;
    release dut.ret_q;
    bubble();
    step();
    total++;
    if (bus.retired !== 32'd0) begin
      bad++;
      $display("FAIL wrap: got %h req 0", bus.retired);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_alu();
    test_loads();
    test_link();
    test_hilo();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
